// File: rtl/reset_request_scheduler_pkg.sv
// Shared types, default parameters and helpers for the reset request scheduler.
package reset_sched_pkg;

    // Sequencer states; the encoding is fixed so debug views stay stable.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUIESCE = 3'd1,
        ASSERT  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } sched_state_e;

    // Default configuration.
    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_NUM_DOM         = 3;
    localparam int DEF_QUIESCE_TIMEOUT = 255;
    localparam int DEF_PULSE_CYCLES    = 8;
    localparam int DEF_GAP_CYCLES      = 4;
    localparam int DEF_CW              = 8;

    // Largest supported requester / domain count.
    localparam int MAX_REQ = 8;
    localparam int MAX_DOM = 8;

    // Priority encoder: index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [2:0] lowest_set_idx(input logic [MAX_DOM-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = MAX_DOM - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reset_request_scheduler_if.sv
// Request / quiesce / domain-reset bundle between requesters, domains and the scheduler.
interface reset_request_scheduler_if
    import reset_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int NUM_DOM = DEF_NUM_DOM
);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*NUM_DOM-1:0] req_mask;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         done;
    logic                       done_timeout;
    logic [NUM_DOM-1:0]         quiesce_req;
    logic [NUM_DOM-1:0]         quiesce_ack;
    logic [NUM_DOM-1:0]         dom_rst;
    logic                       busy;

    // Requester and domain side.
    modport master (
        output req_valid,
        output req_mask,
        output quiesce_ack,
        input  req_ready,
        input  done,
        input  done_timeout,
        input  quiesce_req,
        input  dom_rst,
        input  busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid,
        input  req_mask,
        input  quiesce_ack,
        output req_ready,
        output done,
        output done_timeout,
        output quiesce_req,
        output dom_rst,
        output busy
    );

endinterface

// File: rtl/reset_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// pointer with wrap-around; the pointer moves past the winner on accept.
module rr_arbiter
    import reset_sched_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int            cand;

    // Winner search: first requester at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end else begin
                cand = cand;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
            end else begin
                found = found;
            end
        end
    end

    // Pointer advance: one past the accepted winner, modulo NUM_REQ.
    always_comb begin
        if (accept) begin
            if (gnt_idx == IW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/reset_request_scheduler.sv
// Soft-reset request scheduler: picks one requester round-robin, asks the
// masked domains to quiesce, pulses their resets together, releases them one
// by one in ascending order and reports completion to the requester.
module reset_request_scheduler
    import reset_sched_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int NUM_DOM         = DEF_NUM_DOM,
    parameter int QUIESCE_TIMEOUT = DEF_QUIESCE_TIMEOUT,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int CW              = DEF_CW
) (
    input logic                      clk,
    input logic                      rst,
    reset_request_scheduler_if.slave bus
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Largest value the shared counter must represent.
    localparam int MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (QUIESCE_TIMEOUT > MAX_PG) ? QUIESCE_TIMEOUT : MAX_PG;

    // Terminal counter values; each phase ends when the counter equals these.
    localparam int QT_LAST_I = (QUIESCE_TIMEOUT > 0) ? QUIESCE_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] QT_LAST    = CW'(QT_LAST_I);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

    // Elaboration-time legality checks; a bad configuration must not build.
    if (NUM_REQ < 1 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("reset_request_scheduler: NUM_REQ must be 1..8");
    end
    if (NUM_DOM < 1 || NUM_DOM > MAX_DOM) begin : g_bad_num_dom
        $error("reset_request_scheduler: NUM_DOM must be 1..8");
    end
    if (QUIESCE_TIMEOUT < 0 || PULSE_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
        $error("reset_request_scheduler: PULSE_CYCLES and GAP_CYCLES must be >= 1");
    end
    if (CW < 1 || CW > 30 || MAX_CNT >= (1 << CW)) begin : g_bad_cw
        $error("reset_request_scheduler: CW too narrow for the configured cycle counts");
    end

    sched_state_e       state_q, state_d;
    logic [IW-1:0]      gnt_id_q, gnt_id_d;
    logic [NUM_DOM-1:0] mask_q, mask_d;
    logic [NUM_DOM-1:0] pend_q, pend_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tflag_q, tflag_d;

    logic [NUM_DOM-1:0] quiesce_req_q, quiesce_req_d;
    logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               done_timeout_q, done_timeout_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic [NUM_REQ-1:0] req_ready;
    logic               accept;
    logic [NUM_DOM-1:0] sel_mask;
    logic [2:0]         next_dom;
    logic [NUM_DOM-1:0] pend_clr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .accept  (accept),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Handshake: only the arbiter winner is offered ready, and only while idle.
    always_comb begin
        if (state_q == IDLE) begin
            req_ready = arb_gnt;
        end else begin
            req_ready = '0;
        end
        accept = |(bus.req_valid & req_ready);
    end

    // Mask slice of the current winner.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_mask = bus.req_mask[i*NUM_DOM +: NUM_DOM];
            end else begin
                sel_mask = sel_mask;
            end
        end
    end

    // Next domain to release: lowest domain still held in reset.
    always_comb begin
        next_dom = lowest_set_idx(MAX_DOM'(pend_q));
        pend_clr = pend_q & ~(NUM_DOM'(1) << next_dom);
    end

    // Next-state logic for the sequencer and its shared counter.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        mask_d   = mask_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        tflag_d  = tflag_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    gnt_id_d = arb_idx;
                    mask_d   = sel_mask;
                    pend_d   = sel_mask;
                    cnt_d    = '0;
                    tflag_d  = 1'b0;
                    if (sel_mask != '0) begin
                        state_d = QUIESCE;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            QUIESCE: begin
                if ((bus.quiesce_ack & mask_q) == mask_q) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else if (QUIESCE_TIMEOUT == 0) begin
                    // No wait configured: move on without flagging a timeout.
                    state_d = ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == QT_LAST) begin
                    state_d = ASSERT;
                    cnt_d   = '0;
                    tflag_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    // Pulse complete: first masked domain leaves reset now.
                    state_d = RELEASE;
                    pend_d  = pend_clr;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (pend_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    pend_d = pend_clr;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        quiesce_req_d  = '0;
        dom_rst_d      = '0;
        done_d         = '0;
        done_timeout_d = 1'b0;
        busy_d         = (state_d != IDLE);
        case (state_d)
            QUIESCE: begin
                quiesce_req_d = mask_d;
            end
            ASSERT: begin
                quiesce_req_d = mask_d;
                dom_rst_d     = pend_d;
            end
            RELEASE: begin
                dom_rst_d = pend_d;
            end
            DONE: begin
                done_d         = NUM_REQ'(1) << gnt_id_d;
                done_timeout_d = tflag_d;
            end
            default: begin
                quiesce_req_d = '0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            gnt_id_q       <= '0;
            mask_q         <= '0;
            pend_q         <= '0;
            cnt_q          <= '0;
            tflag_q        <= 1'b0;
            quiesce_req_q  <= '0;
            dom_rst_q      <= '0;
            done_q         <= '0;
            done_timeout_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            gnt_id_q       <= gnt_id_d;
            mask_q         <= mask_d;
            pend_q         <= pend_d;
            cnt_q          <= cnt_d;
            tflag_q        <= tflag_d;
            quiesce_req_q  <= quiesce_req_d;
            dom_rst_q      <= dom_rst_d;
            done_q         <= done_d;
            done_timeout_q <= done_timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.quiesce_req  = quiesce_req_q;
    assign bus.dom_rst      = dom_rst_q;
    assign bus.done         = done_q;
    assign bus.done_timeout = done_timeout_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_reset_request_scheduler.sv
// Directed bench for reset_request_scheduler (NUM_REQ=4, NUM_DOM=3,
// QUIESCE_TIMEOUT=20, PULSE=8, GAP=4) with hand-computed cycle expectations.
module tb_reset_request_scheduler;

    localparam int NR = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reset_request_scheduler_if #(.NUM_REQ(NR), .NUM_DOM(ND)) bus ();

    reset_request_scheduler #(
        .NUM_REQ         (NR),
        .NUM_DOM         (ND),
        .QUIESCE_TIMEOUT (20),
        .PULSE_CYCLES    (8),
        .GAP_CYCLES      (4),
        .CW              (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Observation record for the current test.
    int cyc_n;
    int acc_id_q[$];
    int acc_cyc_q[$];
    int done_id_q[$];
    int done_cyc_q[$];
    int done_to_last;
    int q_hi;
    int first_q;
    int first_r;
    int r_hi[ND];
    int last_hi[ND];
    int ready_busy;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clr_stats();
        acc_id_q.delete();
        acc_cyc_q.delete();
        done_id_q.delete();
        done_cyc_q.delete();
        done_to_last = -1;
        q_hi         = 0;
        first_q      = -1;
        first_r      = -1;
        ready_busy   = 0;
        for (int d = 0; d < ND; d++) begin
            r_hi[d]    = 0;
            last_hi[d] = -1;
        end
    endtask

    task automatic post(input int id, input logic [ND-1:0] m);
        bus.req_mask[id*ND +: ND] = m;
        bus.req_valid[id]         = 1'b1;
    endtask

    // One clock: observe the handshake before the edge, outputs after it.
    task automatic cyc();
        logic [NR-1:0] acc;
        #1;
        acc = bus.req_valid & bus.req_ready;
        if (bus.busy && bus.req_ready != '0) ready_busy++;
        @(posedge clk);
        #2;
        cyc_n++;
        if (acc != '0) begin
            check_val("accept_onehot", $countones(acc), 1);
            for (int i = 0; i < NR; i++) begin
                if (acc[i]) acc_id_q.push_back(i);
            end
            acc_cyc_q.push_back(cyc_n);
            bus.req_valid = bus.req_valid & ~acc;
        end
        if (bus.quiesce_req != '0) begin
            q_hi++;
            if (first_q < 0) first_q = cyc_n;
        end
        if (bus.dom_rst != '0 && first_r < 0) first_r = cyc_n;
        for (int d = 0; d < ND; d++) begin
            if (bus.dom_rst[d]) begin
                r_hi[d]++;
                last_hi[d] = cyc_n;
            end
        end
        if (bus.done != '0) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.done[i]) done_id_q.push_back(i);
            end
            done_cyc_q.push_back(cyc_n);
            done_to_last = int'(bus.done_timeout);
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    initial begin
        int a;
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_mask    = '0;
        bus.quiesce_ack = '0;
        cyc_n           = 0;
        clr_stats();

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_dom_rst", int'(bus.dom_rst), 0);
        check_val("rst_quiesce_req", int'(bus.quiesce_req), 0);
        check_val("rst_done", int'(bus.done), 0);
        check_val("rst_done_timeout", int'(bus.done_timeout), 0);
        check_val("rst_busy", int'(bus.busy), 0);
        bus.req_valid = 4'b1111;
        #1;
        check_val("rst_rr_ptr_ready", int'(bus.req_ready), 1);
        bus.req_valid = '0;
        rst = 1'b0;

        // Single request, mask 101, acks high.
        clr_stats();
        bus.quiesce_ack = 3'b111;
        post(0, 3'b101);
        run(20);
        a = qat(acc_cyc_q, 0);
        check_val("single_acc_id", qat(acc_id_q, 0), 0);
        check_val("single_qreq_start", first_q, a);
        check_val("single_rst_start", first_r, a + 1);
        check_val("single_d0_hi", r_hi[0], 8);
        check_val("single_d1_hi", r_hi[1], 0);
        check_val("single_d2_hi", r_hi[2], 12);
        check_val("single_qreq_hi", q_hi, 9);
        check_val("single_done_count", done_cyc_q.size(), 1);
        check_val("single_done_cyc", qat(done_cyc_q, 0), a + 14);
        check_val("single_done_after_d2", qat(done_cyc_q, 0), last_hi[2] + 2);
        check_val("single_done_id", qat(done_id_q, 0), 0);
        check_val("single_done_to", done_to_last, 0);
        check_val("single_busy_end", int'(bus.busy), 0);

        // Round-robin from a freshly reset pointer.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clr_stats();
        for (int i = 0; i < NR; i++) post(i, 3'b001);
        run(60);
        for (int i = 0; i < NR; i++) begin
            check_val($sformatf("rr_acc_%0d", i), qat(acc_id_q, i), i);
            check_val($sformatf("rr_done_%0d", i), qat(done_id_q, i), i);
        end
        check_val("rr_spacing", qat(acc_cyc_q, 1) - qat(acc_cyc_q, 0), 12);
        check_val("rr_ready_busy", ready_busy, 0);

        clr_stats();
        post(1, 3'b001);
        post(3, 3'b001);
        run(30);
        check_val("rr2_acc_0", qat(acc_id_q, 0), 1);
        check_val("rr2_acc_1", qat(acc_id_q, 1), 3);

        // Busy blocking: req1 raised during req0's reset pulse.
        clr_stats();
        post(0, 3'b001);
        run(4);
        post(1, 3'b010);
        #1;
        check_val("busy_ready", int'(bus.req_ready), 0);
        run(40);
        check_val("busy_acc_0", qat(acc_id_q, 0), 0);
        check_val("busy_acc_1", qat(acc_id_q, 1), 1);
        check_val("busy_first_idle", qat(acc_cyc_q, 1) - qat(acc_cyc_q, 0), 12);
        check_val("busy_ready_viol", ready_busy, 0);

        // Quiesce timeout: ack[1] stuck low.
        clr_stats();
        bus.quiesce_ack = 3'b101;
        post(0, 3'b011);
        run(45);
        a = qat(acc_cyc_q, 0);
        check_val("to_acc_id", qat(acc_id_q, 0), 0);
        check_val("to_qreq_start", first_q, a);
        check_val("to_rst_start", first_r, a + 20);
        check_val("to_qreq_hi", q_hi, 28);
        check_val("to_d0_hi", r_hi[0], 8);
        check_val("to_d1_hi", r_hi[1], 12);
        check_val("to_done_cyc", qat(done_cyc_q, 0), a + 33);
        check_val("to_done_flag", done_to_last, 1);
        bus.quiesce_ack = 3'b111;

        // Zero mask goes straight to completion.
        clr_stats();
        post(2, 3'b000);
        run(5);
        a = qat(acc_cyc_q, 0);
        check_val("zero_done_cyc", qat(done_cyc_q, 0), a);
        check_val("zero_done_id", qat(done_id_q, 0), 2);
        check_val("zero_qreq_hi", q_hi, 0);
        check_val("zero_rst_seen", first_r, -1);
        check_val("zero_done_to", done_to_last, 0);

        // Reset in the middle of the release phase.
        clr_stats();
        post(0, 3'b111);
        run(11);
        check_val("mid_dom_rst", int'(bus.dom_rst), 6);
        check_val("mid_qreq", int'(bus.quiesce_req), 0);
        check_val("mid_busy", int'(bus.busy), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_val("abort_dom_rst", int'(bus.dom_rst), 0);
        check_val("abort_qreq", int'(bus.quiesce_req), 0);
        check_val("abort_done", int'(bus.done), 0);
        check_val("abort_busy", int'(bus.busy), 0);
        post(0, 3'b010);
        post(1, 3'b010);
        run(25);
        check_val("after_acc_0", qat(acc_id_q, 1), 0);
        check_val("after_acc_1", qat(acc_id_q, 2), 1);
        check_val("after_done_count", done_id_q.size(), 2);
        check_val("after_done_0", qat(done_id_q, 0), 0);
        check_val("after_done_1", qat(done_id_q, 1), 1);
        check_val("after_done_to", done_to_last, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
